// File: rtl/qspi_flash_pkg.sv
// Shared opcodes, status register values and FSM states for the QSPI flash emulator.
package qspi_flash_pkg;

    localparam logic [7:0] CMD_READ    = 8'h03;
    localparam logic [7:0] CMD_FREAD   = 8'h0B;
    localparam logic [7:0] CMD_QOREAD  = 8'h6B;
    localparam logic [7:0] CMD_QIOREAD = 8'hEB;
    localparam logic [7:0] CMD_JEDEC   = 8'h9F;
    localparam logic [7:0] CMD_RDSR1   = 8'h05;
    localparam logic [7:0] CMD_RDSR2   = 8'h35;

    localparam logic [7:0] SR1_VALUE = 8'h00;
    localparam logic [7:0] SR2_VALUE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_SINK
    } state_t;

    // Quad I/O counts its two ignored mode clocks as part of the dummy phase.
    function automatic logic [4:0] dummy_clocks(input logic [7:0] opcode);
        case (opcode)
            CMD_FREAD, CMD_QOREAD: return 5'd8;
            CMD_QIOREAD:           return 5'd6;
            default:               return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/qspi_pin_sync.sv
// Synchronizes the SPI pins into the system clock domain and derives SCLK
// rise/fall pulses and the chip-select falling edge.
module qspi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       csn_i,
    input  logic       sclk_i,
    input  logic [3:0] io_i,
    output logic       csn_s,
    output logic [3:0] io_s,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       csn_fall
);

    logic [5:0] sync_q [SYNC_STAGES];
    logic       sclk_s;
    logic       sclk_prev;
    logic       csn_prev;

    // csn resets to "selected" so a chip select held low through reset never
    // produces a falling edge; the master must deselect first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 6'b000000;
            end
            sclk_prev <= 1'b0;
            csn_prev  <= 1'b0;
        end else begin
            sync_q[0] <= {csn_i, sclk_i, io_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sclk_prev <= sclk_s;
            csn_prev  <= csn_s;
        end
    end

    assign csn_s     = sync_q[SYNC_STAGES-1][5];
    assign sclk_s    = sync_q[SYNC_STAGES-1][4];
    assign io_s      = sync_q[SYNC_STAGES-1][3:0];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign csn_fall  = ~csn_s & csn_prev;

endmodule

// File: rtl/qspi_flash_emu.sv
// Read-only quad-SPI NOR flash emulator, oversampling the SPI pins with clk
// and serving a backdoor-loaded byte array.
module qspi_flash_emu
    import qspi_flash_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 16,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_csn_i,
    input  logic                  spi_clk_i,
    input  logic [3:0]            spi_io_i,
    output logic [3:0]            spi_io_o,
    output logic [3:0]            spi_io_oe,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [7:0]            load_data
);

    logic                  csn_s;
    logic [3:0]            io_s;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  csn_fall;

    state_t                state;
    state_t                state_next;
    logic [7:0]            cmd_sr;
    logic [7:0]            cmd_byte;
    logic [7:0]            opcode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [4:0]            bit_cnt;
    logic [4:0]            phase_last;
    logic                  phase_done;
    logic [2:0]            pos;
    logic [1:0]            byte_idx;
    logic                  quad_in;
    logic                  quad_out;
    logic                  byte_last;
    logic [7:0]            data_byte;
    logic [7:0]            mem_q;
    logic [7:0]            mem [(1 << ADDR_WIDTH)];

    qspi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_pin_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .csn_i    (spi_csn_i),
        .sclk_i   (spi_clk_i),
        .io_i     (spi_io_i),
        .csn_s    (csn_s),
        .io_s     (io_s),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .csn_fall (csn_fall)
    );

    assign cmd_byte  = {cmd_sr[6:0], io_s[0]};
    assign quad_in   = (opcode == CMD_QIOREAD);
    assign quad_out  = (opcode == CMD_QOREAD) || (opcode == CMD_QIOREAD);
    assign byte_last = quad_out ? pos[0] : (pos == 3'd7);

    always_comb begin
        phase_last = 5'd31;
        case (state)
            ST_CMD:   phase_last = 5'd7;
            ST_ADDR:  phase_last = quad_in ? 5'd5 : 5'd23;
            ST_DUMMY: phase_last = dummy_clocks(opcode) - 5'd1;
            default:  phase_last = 5'd31;
        endcase
        phase_done = sclk_rise && (bit_cnt == phase_last);
    end

    always_comb begin
        data_byte = mem_q;
        case (opcode)
            CMD_JEDEC: begin
                case (byte_idx)
                    2'd0:    data_byte = JEDEC_ID[23:16];
                    2'd1:    data_byte = JEDEC_ID[15:8];
                    default: data_byte = JEDEC_ID[7:0];
                endcase
            end
            CMD_RDSR1: data_byte = SR1_VALUE;
            CMD_RDSR2: data_byte = SR2_VALUE;
            default:   data_byte = mem_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Deselect overrides every transition so aborts work from any phase.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (csn_fall) state_next = ST_CMD;
            end
            ST_CMD: begin
                if (phase_done) begin
                    case (cmd_byte)
                        CMD_READ, CMD_FREAD, CMD_QOREAD, CMD_QIOREAD: state_next = ST_ADDR;
                        CMD_JEDEC, CMD_RDSR1, CMD_RDSR2:              state_next = ST_DATA;
                        default:                                      state_next = ST_SINK;
                    endcase
                end
            end
            ST_ADDR: begin
                if (phase_done) state_next = (dummy_clocks(opcode) == 5'd0) ? ST_DATA : ST_DUMMY;
            end
            ST_DUMMY: begin
                if (phase_done) state_next = ST_DATA;
            end
            default: state_next = state;
        endcase
        if (csn_s) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_sr    <= 8'h00;
            opcode    <= 8'h00;
            addr      <= '0;
            bit_cnt   <= 5'd0;
            pos       <= 3'd0;
            byte_idx  <= 2'd0;
            spi_io_o  <= 4'h0;
            spi_io_oe <= 4'h0;
        end else if (csn_s) begin
            bit_cnt   <= 5'd0;
            pos       <= 3'd0;
            byte_idx  <= 2'd0;
            spi_io_o  <= 4'h0;
            spi_io_oe <= 4'h0;
        end else begin
            if (sclk_rise) begin
                case (state)
                    ST_CMD: begin
                        cmd_sr <= cmd_byte;
                        if (phase_done) opcode <= cmd_byte;
                    end
                    ST_ADDR: begin
                        addr <= quad_in ? {addr[ADDR_WIDTH-5:0], io_s}
                                        : {addr[ADDR_WIDTH-2:0], io_s[0]};
                    end
                    default: ;
                endcase
                if (state inside {ST_CMD, ST_ADDR, ST_DUMMY}) begin
                    bit_cnt <= phase_done ? 5'd0 : bit_cnt + 5'd1;
                end
            end
            if (sclk_fall && (state == ST_DATA)) begin
                if (quad_out) begin
                    spi_io_oe <= 4'b1111;
                    spi_io_o  <= pos[0] ? data_byte[3:0] : data_byte[7:4];
                end else begin
                    spi_io_oe <= 4'b0010;
                    spi_io_o  <= {2'b00, data_byte[3'd7 - pos], 1'b0};
                end
                if (byte_last) begin
                    pos      <= 3'd0;
                    addr     <= addr + 1'b1;
                    byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
                end else begin
                    pos <= pos + 3'd1;
                end
            end
        end
    end

    // Registered array read; the address settles many clk before the next fall.
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        mem_q <= mem[addr];
    end

endmodule

// File: tb/tb_qspi_flash_emu.sv
// Directed and randomized QSPI master driving qspi_flash_emu, checked against
// a byte-array reference of the flash contents.
module tb_qspi_flash_emu;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_csn_i;
    logic        spi_clk_i;
    logic [3:0]  spi_io_i;
    logic [3:0]  spi_io_o;
    logic [3:0]  spi_io_oe;
    logic        load_en;
    logic [15:0] load_addr;
    logic [7:0]  load_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  ref_mem [65536];

    always #5 clk = ~clk;

    qspi_flash_emu #(
        .ADDR_WIDTH (16),
        .JEDEC_ID   (24'hEF4018),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_csn_i(spi_csn_i),
        .spi_clk_i(spi_clk_i),
        .spi_io_i (spi_io_i),
        .spi_io_o (spi_io_o),
        .spi_io_oe(spi_io_oe),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data)
    );

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One SCLK period: drive lanes while low, sample just before the rise.
    task automatic applyStimulus(input logic [3:0] drive, output logic [3:0] s_io, output logic [3:0] s_oe);
        spi_io_i = drive;
        waitClk(HALF);
        s_io = spi_io_o;
        s_oe = spi_io_oe;
        spi_clk_i = 1'b1;
        waitClk(HALF);
        spi_clk_i = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic [3:0] s_io, s_oe;
        for (int i = 7; i >= 0; i--) applyStimulus({3'b000, b[i]}, s_io, s_oe);
    endtask

    task automatic sendAddr(input logic [23:0] a, input bit quad);
        logic [3:0] s_io, s_oe;
        if (quad) begin
            for (int k = 0; k < 6; k++) applyStimulus(a[23-4*k -: 4], s_io, s_oe);
        end else begin
            for (int k = 0; k < 24; k++) applyStimulus({3'b000, a[23-k]}, s_io, s_oe);
        end
    endtask

    task automatic idleClocks(input int n, input logic [3:0] drive, output logic [3:0] oe_or);
        logic [3:0] s_io, s_oe;
        oe_or = 4'h0;
        for (int k = 0; k < n; k++) begin
            applyStimulus(drive, s_io, s_oe);
            oe_or = oe_or | s_oe;
        end
    endtask

    task automatic readByte(input bit quad, output logic [7:0] b, output logic [3:0] oe_last);
        logic [3:0] s_io, s_oe;
        b = 8'h00;
        if (quad) begin
            applyStimulus(4'h0, s_io, s_oe);
            b[7:4] = s_io;
            applyStimulus(4'h0, s_io, s_oe);
            b[3:0] = s_io;
        end else begin
            for (int k = 0; k < 8; k++) begin
                applyStimulus(4'h0, s_io, s_oe);
                b = {b[6:0], s_io[1]};
            end
        end
        oe_last = s_oe;
    endtask

    task automatic startTxn();
        spi_clk_i = 1'b0;
        spi_csn_i = 1'b0;
        waitClk(HALF);
    endtask

    // Deselect and confirm the lanes are released SYNC_STAGES+1 clk later.
    task automatic endTxn(input string tag);
        spi_csn_i = 1'b1;
        waitClk(3);
        checkOutput({tag, " oe after csn"}, {28'h0, spi_io_oe}, 32'h0);
        waitClk(2 * HALF);
    endtask

    task automatic loadByte(input logic [15:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        waitClk(1);
        load_en   = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic readTxn(input logic [7:0] op, input logic [23:0] a, input int nbytes, input string tag);
        logic [7:0]  b;
        logic [3:0]  oe, oe_or;
        logic [15:0] idx;
        bit          quad;
        quad = (op == 8'h6B) || (op == 8'hEB);
        startTxn();
        sendByte(op);
        sendAddr(a, op == 8'hEB);
        if (op == 8'h0B || op == 8'h6B) idleClocks(8, 4'h0, oe_or);
        if (op == 8'hEB) begin
            idleClocks(1, 4'hF, oe_or);
            idleClocks(5, 4'h0, oe_or);
        end
        for (int i = 0; i < nbytes; i++) begin
            readByte(quad, b, oe);
            idx = a[15:0] + 16'(i);
            checkOutput($sformatf("%s byte%0d", tag, i), {24'h0, b}, {24'h0, ref_mem[idx]});
            checkOutput($sformatf("%s oe%0d", tag, i), {28'h0, oe}, quad ? 32'hF : 32'h2);
        end
        endTxn(tag);
    endtask

    task automatic regTxn(input logic [7:0] op, input int nbytes, input string tag);
        logic [7:0]  b, exp_b;
        logic [3:0]  oe;
        logic [23:0] id;
        id = 24'hEF4018;
        startTxn();
        sendByte(op);
        for (int i = 0; i < nbytes; i++) begin
            readByte(1'b0, b, oe);
            case (op)
                8'h9F:   exp_b = id[23 - 8*(i % 3) -: 8];
                8'h35:   exp_b = 8'h02;
                default: exp_b = 8'h00;
            endcase
            checkOutput($sformatf("%s byte%0d", tag, i), {24'h0, b}, {24'h0, exp_b});
            checkOutput($sformatf("%s oe%0d", tag, i), {28'h0, oe}, 32'h2);
        end
        endTxn(tag);
    endtask

    initial begin
        logic [3:0]  oe_or;
        logic [3:0]  s_io, s_oe;
        logic [7:0]  ops [4];
        logic [7:0]  op;
        logic [23:0] a;

        ops[0] = 8'h03; ops[1] = 8'h0B; ops[2] = 8'h6B; ops[3] = 8'hEB;
        rst_n = 1'b0; spi_csn_i = 1'b0; spi_clk_i = 1'b0; spi_io_i = 4'h0;
        load_en = 1'b0; load_addr = 16'h0; load_data = 8'h0;

        for (int i = 0; i < 5; i++) begin
            spi_clk_i = ~spi_clk_i;
            waitClk(1);
        end
        checkOutput("reset oe", {28'h0, spi_io_oe}, 32'h0);
        checkOutput("reset io", {28'h0, spi_io_o}, 32'h0);
        rst_n = 1'b1;
        spi_clk_i = 1'b0;
        waitClk(4);

        sendByte(8'h9F);
        idleClocks(16, 4'h0, oe_or);
        checkOutput("no command before csn rise", {28'h0, oe_or}, 32'h0);
        spi_csn_i = 1'b1;
        waitClk(2 * HALF);

        loadByte(16'h0010, 8'h11);
        loadByte(16'h0011, 8'h22);
        loadByte(16'h0012, 8'h33);
        loadByte(16'h0013, 8'h44);
        loadByte(16'hFFFF, 8'hA5);
        loadByte(16'h0000, 8'h5A);
        for (int i = 0; i < 256; i++) loadByte(16'h2000 + 16'(i), 8'($urandom));

        regTxn(8'h9F, 6, "jedec");
        regTxn(8'h05, 2, "rdsr1");
        regTxn(8'h35, 2, "rdsr2");

        readTxn(8'h03, 24'h000010, 4, "read");
        readTxn(8'h0B, 24'h000010, 4, "fast read");
        readTxn(8'h6B, 24'h00FFFF, 2, "quad wrap");
        readTxn(8'hEB, 24'h000010, 2, "quad io");

        for (int t = 0; t < 8; t++) begin
            op = ops[$urandom_range(0, 3)];
            a  = {8'($urandom), 16'h2000 + 16'($urandom_range(0, 250))};
            $display("[TB] random txn %0d op=%h addr=%h", t, op, a);
            readTxn(op, a, 4, $sformatf("random%0d", t));
        end

        startTxn();
        sendByte(8'h03);
        sendAddr(24'h000010, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(4'h0, s_io, s_oe);
        endTxn("abort");
        regTxn(8'h05, 1, "rdsr1 after abort");

        startTxn();
        sendByte(8'hFF);
        idleClocks(16, 4'h0, oe_or);
        checkOutput("unknown opcode oe", {28'h0, oe_or}, 32'h0);
        endTxn("unknown");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
